// File: rtl/bin_loader_if.sv
// Bus between a BIN paper-tape frame source / memory and the loader.
//   master : tape reader + memory side (drives frames and mem_finished)
//   slave  : bin_loader (accepts frames, issues writes, reports status)
interface bin_loader_if;
  logic [7:0]  frame_data;
  logic        frame_valid;
  logic        frame_ready;
  logic        write_enable;
  logic [11:0] address;
  logic [11:0] write_data;
  logic        mem_finished;
  logic [11:0] start_pc;
  logic [12:0] words_loaded;
  logic        load_done;
  logic        load_error;

  modport master (
    output frame_data, frame_valid, mem_finished,
    input  frame_ready, write_enable, address, write_data,
           start_pc, words_loaded, load_done, load_error
  );

  modport slave (
    input  frame_data, frame_valid, mem_finished,
    output frame_ready, write_enable, address, write_data,
           start_pc, words_loaded, load_done, load_error
  );
endinterface

// File: rtl/bin_loader.sv
// BIN paper-tape loader: assembles 12-bit words from pairs of 6-bit frames,
// handles origin pairs, and writes data words to memory with a handshake.
// Ports:
//   i_clk    : system clock, all state changes on rising edge
//   i_reset  : synchronous active-high reset
//   io_bus   : bin_loader_if.slave (frames in, memory write out, status out)
module bin_loader #(
  parameter logic [11:0] DEFAULT_ORIGIN = 12'o0200,
  parameter int unsigned MAX_WAIT       = 64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  bin_loader_if.slave io_bus
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    LEADER = 3'd0,
    HIGH   = 3'd1,
    LOW    = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } state_t;

  state_t           r_state;
  logic [6:0]       r_high;          // origin marker + payload of the high frame
  logic             r_frame_ready;
  logic             r_write_enable;
  logic [11:0]      r_address;
  logic [11:0]      r_write_data;
  logic [11:0]      r_start_pc;
  logic [12:0]      r_words_loaded;
  logic             r_load_done;
  logic             r_load_error;
  logic             r_origin_seen;
  logic [CNT_W-1:0] r_wait_cnt;

  logic        w_take;
  logic [11:0] w_word;

  assign w_take = io_bus.frame_valid & r_frame_ready;
  assign w_word = {r_high[5:0], io_bus.frame_data[5:0]};

  // Loader FSM with registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= LEADER;
      r_high         <= 7'd0;
      r_frame_ready  <= 1'b1;
      r_write_enable <= 1'b0;
      r_address      <= DEFAULT_ORIGIN;
      r_write_data   <= 12'd0;
      r_start_pc     <= DEFAULT_ORIGIN;
      r_words_loaded <= 13'd0;
      r_load_done    <= 1'b0;
      r_load_error   <= 1'b0;
      r_origin_seen  <= 1'b0;
      r_wait_cnt     <= '0;
    end else begin
      case (r_state)
        LEADER: begin
          // leader frames are skipped; first non-leader frame is a high frame
          if (w_take && !io_bus.frame_data[7]) begin
            r_high  <= io_bus.frame_data[6:0];
            r_state <= LOW;
          end
        end
        HIGH: begin
          if (w_take) begin
            if (io_bus.frame_data[7]) begin
              r_state       <= DONE;
              r_frame_ready <= 1'b0;
              r_load_done   <= 1'b1;
            end else begin
              r_high  <= io_bus.frame_data[6:0];
              r_state <= LOW;
            end
          end
        end
        LOW: begin
          if (w_take) begin
            if (io_bus.frame_data[7] || io_bus.frame_data[6]) begin
              r_state       <= ERROR;
              r_frame_ready <= 1'b0;
              r_load_error  <= 1'b1;
            end else if (r_high[6]) begin
              // origin pair: relocate, no memory write
              r_address <= w_word;
              if (!r_origin_seen) begin
                r_start_pc    <= w_word;
                r_origin_seen <= 1'b1;
              end
              r_state <= HIGH;
            end else begin
              r_write_data   <= w_word;
              r_write_enable <= 1'b1;
              r_wait_cnt     <= '0;
              r_frame_ready  <= 1'b0;
              r_state        <= WRITE;
            end
          end
        end
        WRITE: begin
          if (io_bus.mem_finished) begin
            r_write_enable <= 1'b0;
            r_address      <= r_address + 12'd1;
            if (r_words_loaded != 13'h1FFF) begin
              r_words_loaded <= r_words_loaded + 13'd1;
            end
            r_frame_ready <= 1'b1;
            r_state       <= HIGH;
          end else if (r_wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
            r_write_enable <= 1'b0;
            r_load_error   <= 1'b1;
            r_state        <= ERROR;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        DONE, ERROR: begin
          r_frame_ready  <= 1'b0;
          r_write_enable <= 1'b0;
        end
        default: begin
          r_state        <= ERROR;
          r_frame_ready  <= 1'b0;
          r_write_enable <= 1'b0;
          r_load_error   <= 1'b1;
        end
      endcase
    end
  end

  assign io_bus.frame_ready  = r_frame_ready;
  assign io_bus.write_enable = r_write_enable;
  assign io_bus.address      = r_address;
  assign io_bus.write_data   = r_write_data;
  assign io_bus.start_pc     = r_start_pc;
  assign io_bus.words_loaded = r_words_loaded;
  assign io_bus.load_done    = r_load_done;
  assign io_bus.load_error   = r_load_error;

endmodule
